// File: rtl/hex_score_display.sv
// Signed multi-channel score to 7-segment converter.
// One shared double-dabble engine sweeps channels round-robin.
module hex_score_display #(
  parameter int NUM_CH   = 2,
  parameter int VAL_W    = 8,
  parameter int DIGITS   = 2,
  parameter int LZ_BLANK = 1
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           start,
  input  logic [NUM_CH*VAL_W-1:0]        values,
  output logic [NUM_CH*(DIGITS+1)*8-1:0] hex_out,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CH-1:0]              ovf
);

  function automatic int bcd_w(input int w);
    longint v;
    int     n;
    v = longint'(1) << w;
    n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  localparam int NB    = bcd_w(VAL_W);
  localparam int XD    = (NB > DIGITS) ? NB : DIGITS;
  localparam int DW    = (DIGITS + 1) * 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(VAL_W + 1);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_CH*VAL_W-1:0] r_snap;
  logic [CH_W-1:0]         r_ch;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sign;
  logic [VAL_W-1:0]        r_mag;
  logic [NB*4-1:0]         r_bcd;
  logic                    r_pend;
  logic                    r_busy;
  logic                    r_done;
  logic [NUM_CH*DW-1:0]    r_hex;
  logic [NUM_CH-1:0]       r_ovf;

  logic             w_last_ch;
  logic             w_last_bit;
  logic             w_latch_en;
  logic             w_shift_en;
  logic             w_write_en;
  logic             w_sweep_end;
  logic             w_launch;
  logic [VAL_W-1:0] w_val;
  logic [NB*4-1:0]  w_bcd_adj;
  logic [XD*4-1:0]  w_bcd_x;
  logic             w_ovf;
  logic [DW-1:0]    w_disp;

  assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
  assign w_last_bit = (r_cnt == CNT_W'(VAL_W - 1));
  assign w_val      = r_snap[r_ch*VAL_W +: VAL_W];
  assign w_bcd_x    = (XD*4)'(r_bcd);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_LATCH;
      S_LATCH: w_next = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_next = S_WRITE;
      S_WRITE: begin
        if (!w_last_ch)          w_next = S_LATCH;
        else if (r_pend || start) w_next = S_LATCH;
        else                     w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch_en  = (r_state == S_LATCH);
    w_shift_en  = (r_state == S_SHIFT);
    w_write_en  = (r_state == S_WRITE);
    w_sweep_end = w_write_en && w_last_ch;
    w_launch    = ((r_state == S_IDLE) && start)
                || (w_sweep_end && (r_pend || start));
  end

  // Add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NB; k++) begin
      if (r_bcd[k*4 +: 4] >= 4'd5)
        w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
    end
  end

  always_comb begin : p_disp
    logic [3:0] dig;
    logic       lead;
    w_ovf = 1'b0;
    for (int k = DIGITS; k < XD; k++) begin
      if (w_bcd_x[k*4 +: 4] != 4'd0) w_ovf = 1'b1;
    end
    lead   = 1'b1;
    dig    = 4'd0;
    w_disp = '1;
    w_disp[DIGITS*8 +: 8] = r_sign ? 8'hBF : 8'hFF;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig  = w_ovf ? 4'd9 : w_bcd_x[d*4 +: 4];
      lead = lead && (dig == 4'd0);
      if ((LZ_BLANK != 0) && (d != 0) && lead)
        w_disp[d*8 +: 8] = 8'hFF;
      else
        w_disp[d*8 +: 8] = seg7(dig);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_snap <= '0;
      r_ch   <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_mag  <= '0;
      r_bcd  <= '0;
      r_pend <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hex  <= '1;
      r_ovf  <= '0;
    end else begin
      r_done <= w_sweep_end;
      r_busy <= (w_next != S_IDLE);
      if (w_launch) r_snap <= values;
      if (w_launch)
        r_pend <= 1'b0;
      else if (start && (r_state != S_IDLE))
        r_pend <= 1'b1;
      if (w_launch)
        r_ch <= '0;
      else if (w_write_en && !w_last_ch)
        r_ch <= r_ch + 1'b1;
      // Magnitude is unsigned so the most negative value does not wrap
      if (w_latch_en) begin
        r_cnt  <= '0;
        r_sign <= w_val[VAL_W-1];
        r_mag  <= w_val[VAL_W-1] ? -w_val : w_val;
        r_bcd  <= '0;
      end
      if (w_shift_en) begin
        r_cnt          <= r_cnt + 1'b1;
        {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
      end
      if (w_write_en) begin
        r_hex[r_ch*DW +: DW] <= w_disp;
        r_ovf[r_ch]          <= w_ovf;
      end
    end
  end

  assign hex_out = r_hex;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_hex_score_display.sv
// Scoreboard bench for hex_score_display: random and directed sweeps,
// pending starts and mid-sweep reset, two builds (blanking on/off).
module tb_hex_score_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] values = '0;

  logic [47:0] hex_lz, hex_nz;
  logic        busy, done, busy_nz, done_nz;
  logic [1:0]  ovf, ovf_nz;

  hex_score_display #(
    .NUM_CH(2), .VAL_W(8), .DIGITS(2), .LZ_BLANK(1)
  ) u_dut (
    .Clk(clk), .Reset_n(rst_n), .start(start), .values(values),
    .hex_out(hex_lz), .busy(busy), .done(done), .ovf(ovf)
  );

  hex_score_display #(
    .NUM_CH(2), .VAL_W(8), .DIGITS(2), .LZ_BLANK(0)
  ) u_dut_nz (
    .Clk(clk), .Reset_n(rst_n), .start(start), .values(values),
    .hex_out(hex_nz), .busy(busy_nz), .done(done_nz), .ovf(ovf_nz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] lz;
    logic [47:0] nz;
    logic [1:0]  ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] SEG [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model(input int v, input bit lz);
    int m, t, o;
    logic [7:0] b2, b1, b0;
    m = (v < 0) ? -v : v;
    if (m > 99) m = 99;
    t = m / 10;
    o = m % 10;
    b0 = SEG[o];
    b1 = (lz && t == 0) ? 8'hFF : SEG[t];
    b2 = (v < 0) ? 8'hBF : 8'hFF;
    return {b2, b1, b0};
  endfunction

  function automatic exp_t mk(input int v0, input int v1, input int c);
    exp_t e;
    e.lz  = {model(v1, 1'b1), model(v0, 1'b1)};
    e.nz  = {model(v1, 1'b0), model(v0, 1'b0)};
    e.ovf = {(v1 > 99 || v1 < -99), (v0 > 99 || v0 < -99)};
    e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cyc %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("hex_lz", hex_lz, e.lz);
        chk("hex_nz", hex_nz, e.nz);
        chk("ovf", ovf, e.ovf);
        chk("done_nz", done_nz, 1'b1);
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (!busy && !done) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
  endtask

  task automatic issue(input int v0, input int v1, input bit expect_done);
    wait_idle();
    values = {8'(v1), 8'(v0)};
    start  = 1'b1;
    if (expect_done) sb.push_back(mk(v0, v1, cyc + 21));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_hex"}, hex_lz, 48'hFFFF_FFFF_FFFF);
    chk({tag, "_hexnz"}, hex_nz, 48'hFFFF_FFFF_FFFF);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"}, ovf, 2'b00);
  endtask

  initial begin
    int k, nd, blow;
    #12;
    chk_blank("por");
    @(negedge clk);
    rst_n = 1'b1;

    issue(42, -7, 1'b1);
    issue(-128, 100, 1'b1);
    issue(5, 100, 1'b1);
    issue(0, -1, 1'b1);
    issue(99, -99, 1'b1);
    wait_idle();

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_blank("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    issue(-100, 127, 1'b1);
    wait_idle();
    k = cyc;
    values = {8'(20), 8'(10)};
    start  = 1'b1;
    sb.push_back(mk(10, 20, k + 21));
    nd   = 0;
    blow = 0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (j == 3) values = {8'(77), 8'(-55)};
      if (j == 5) begin
        start = 1'b1;
        sb.push_back(mk(-55, 77, k + 41));
      end
      if (j == 6) start = 1'b0;
      if (done) nd++;
      if (j <= 40 && !busy) blow++;
    end
    chk("pending_dones", nd, 2);
    chk("pending_busy_gaps", blow, 0);

    issue(-3, 64, 1'b0);
    for (int j = 2; j <= 12; j++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_blank("sweep_rst");
    nd = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 2) rst_n = 1'b1;
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);

    issue(13, -50, 1'b1);
    for (int i = 0; i < 10; i++) begin
      issue(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'b1);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
